// File: rtl/status_tx.sv
// Status line transmitter: snapshots game state and streams "S dddd T ccc s CR LF" frames to a UART core.
// Optional STATUS_TX_ANSI_EN macro prefixes each frame with an ANSI clear-line sequence.
module status_tx #(
    parameter int CD_W            = 8,
    parameter int HEARTBEAT_TICKS = 100_000_000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [15:0]     score,
    input  logic [CD_W-1:0] count_down,
    input  logic            start,
    input  logic            over,
    input  logic            is_transmitting,
    output logic            transmit,
    output logic [7:0]      tx_byte
);

`ifdef STATUS_TX_ANSI_EN
    localparam int PRE_LEN = 5;
`else
    localparam int PRE_LEN = 0;
`endif
    localparam logic [4:0] PRE      = 5'(PRE_LEN);
    localparam logic [4:0] LAST_IDX = 5'(PRE_LEN + 13);
    localparam logic [3:0] CONV_END = 4'(CD_W - 1);

    typedef enum logic [2:0] {IDLE, CONV, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state, state_n;
    logic          pending;
    logic [15:0]   prev_score;
    logic [CD_W-1:0] prev_cd;
    logic          prev_start, prev_over;
    logic [15:0]   snap_score;
    logic          snap_start, snap_over;
    logic [9:0]    bin_sr;
    logic [11:0]   bcd, bcd_adj;
    logic [3:0]    conv_cnt;
    logic [4:0]    idx, body_idx;
    logic [1:0]    wb_cnt;
    logic          ev_hit, hb_hit, req;
    logic          take, do_shift, strobe, idx_inc, wb_inc;
    logic [7:0]    frame_byte, status_char;

    function automatic logic [9:0] sat999(input logic [CD_W-1:0] v);
        logic [10:0] ext;
        ext = 11'(v);
        return (ext > 11'd999) ? 10'd999 : ext[9:0];
    endfunction

    function automatic logic [11:0] dabble(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++)
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] n);
        return (n > 4'd9) ? 8'h3F : 8'h30 + {4'h0, n};
    endfunction

    assign ev_hit = (score != prev_score) || (count_down != prev_cd) ||
                    (start != prev_start) || (over != prev_over);
    assign req     = pending | ev_hit | hb_hit;
    assign bcd_adj = dabble(bcd);

    generate
        if (HEARTBEAT_TICKS > 0) begin : g_hb
            logic [31:0] hb_cnt;
            assign hb_hit = (hb_cnt == 32'(HEARTBEAT_TICKS - 1));
            always_ff @(posedge clk) begin
                if (!reset_n || take || hb_hit) hb_cnt <= '0;
                else                             hb_cnt <= hb_cnt + 32'd1;
            end
        end else begin : g_no_hb
            assign hb_hit = 1'b0;
        end
    endgenerate

    // Byte selection from the frozen snapshot and converted countdown
    assign status_char = snap_over ? 8'h4F : (snap_start ? 8'h52 : 8'h49);
    assign body_idx    = idx - PRE;

    always_comb begin
        frame_byte = 8'h00;
        case (body_idx)
            5'd0:  frame_byte = 8'h53;
            5'd1:  frame_byte = digit_char(snap_score[15:12]);
            5'd2:  frame_byte = digit_char(snap_score[11:8]);
            5'd3:  frame_byte = digit_char(snap_score[7:4]);
            5'd4:  frame_byte = digit_char(snap_score[3:0]);
            5'd5:  frame_byte = 8'h20;
            5'd6:  frame_byte = 8'h54;
            5'd7:  frame_byte = digit_char(bcd[11:8]);
            5'd8:  frame_byte = digit_char(bcd[7:4]);
            5'd9:  frame_byte = digit_char(bcd[3:0]);
            5'd10: frame_byte = 8'h20;
            5'd11: frame_byte = status_char;
            5'd12: frame_byte = 8'h0D;
            5'd13: frame_byte = 8'h0A;
            default: frame_byte = 8'h00;
        endcase
`ifdef STATUS_TX_ANSI_EN
        case (idx)
            5'd0: frame_byte = 8'h1B;
            5'd1: frame_byte = 8'h5B;
            5'd2: frame_byte = 8'h32;
            5'd3: frame_byte = 8'h4B;
            5'd4: frame_byte = 8'h0D;
            default: ;
        endcase
`endif
    end

    always_comb begin
        state_n  = state;
        take     = 1'b0;
        do_shift = 1'b0;
        strobe   = 1'b0;
        idx_inc  = 1'b0;
        wb_inc   = 1'b0;
        case (state)
            IDLE: if (req) begin
                take    = 1'b1;
                state_n = CONV;
            end
            CONV: begin
                do_shift = 1'b1;
                if (conv_cnt == CONV_END) state_n = SEND;
            end
            SEND: if (!is_transmitting) begin
                strobe  = 1'b1;
                state_n = WAIT_BUSY;
            end
            // A byte the UART never acknowledges is treated as sent after four cycles
            WAIT_BUSY: begin
                if (is_transmitting || wb_cnt == 2'd3) state_n = WAIT_DONE;
                else                                    wb_inc  = 1'b1;
            end
            WAIT_DONE: if (!is_transmitting) begin
                if (idx == LAST_IDX) state_n = IDLE;
                else begin
                    idx_inc = 1'b1;
                    state_n = SEND;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            pending    <= 1'b1;
            idx        <= '0;
            conv_cnt   <= '0;
            wb_cnt     <= '0;
            transmit   <= 1'b0;
            tx_byte    <= 8'h00;
            prev_score <= '0;
            prev_cd    <= '0;
            prev_start <= 1'b0;
            prev_over  <= 1'b0;
        end else begin
            state      <= state_n;
            // The snapshot already reflects any change seen in the take cycle
            pending    <= take ? 1'b0 : req;
            prev_score <= score;
            prev_cd    <= count_down;
            prev_start <= start;
            prev_over  <= over;
            transmit   <= strobe;
            if (strobe) tx_byte <= frame_byte;
            if (take)         idx <= '0;
            else if (idx_inc) idx <= idx + 5'd1;
            if (take)          conv_cnt <= '0;
            else if (do_shift) conv_cnt <= conv_cnt + 4'd1;
            if (strobe)      wb_cnt <= '0;
            else if (wb_inc) wb_cnt <= wb_cnt + 2'd1;
        end
    end

    // Snapshot and shift-add-3 datapath; value left-aligned so CD_W shifts suffice
    always_ff @(posedge clk) begin
        if (take) begin
            snap_score <= score;
            snap_start <= start;
            snap_over  <= over;
            bin_sr     <= sat999(count_down) << (10 - CD_W);
            bcd        <= '0;
        end else if (do_shift) begin
            {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
        end
    end

endmodule

// File: doc/status_tx.md
STATUS_TX -- requirements
Module: status_tx

Interface
REQ-001 Parameter CD_W, default 8: width of count_down input, legal range 4..10.
REQ-002 Parameter HEARTBEAT_TICKS, default 100_000_000: clk cycles between unconditional frames; 0 disables the heartbeat.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 score  input  16  four BCD digits, [15:12] most significant.
REQ-006 count_down  input  CD_W  binary seconds remaining.
REQ-007 start  input  1  game running flag.
REQ-008 over  input  1  game over flag.
REQ-009 is_transmitting  input  1  UART core busy.
REQ-010 transmit  output  1  one-cycle send strobe to UART core.
REQ-011 tx_byte  output  8  byte to send; valid while transmit=1.

Function
REQ-012 Frame, 14 bytes, in order: 'S', d3, d2, d1, d0, ' ', 'T', c2, c1, c0, ' ', status, CR (0x0D), LF (0x0A).
REQ-013 Each score digit shall be sent as ASCII '0'+nibble; a nibble greater than 9 shall be sent as '?'.
REQ-014 c2..c0 shall be the 3-digit decimal of count_down, zero-padded; values above 999 shall saturate to "999".
REQ-015 Status shall be 'O' if over=1, else 'R' if start=1, else 'I'.
REQ-016 Score, count_down, start and over shall be snapshotted when a frame leaves IDLE; the whole frame uses the snapshot.
REQ-017 Event: any cycle where score, count_down, start or over differs from its value in the previous cycle; an event sets pending.
REQ-018 Heartbeat counter shall set pending on reaching HEARTBEAT_TICKS-1, then wrap to 0; it restarts at 0 whenever a frame starts.
REQ-019 Events during a frame shall set pending; multiple events shall coalesce into one follow-up frame; no event is lost.
REQ-020 FSM states: IDLE, CONV, SEND, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE -> CONV when pending=1; pending clears and the snapshot is taken in the same cycle.
REQ-022 CONV: iterative binary-to-BCD of the snapshot count_down over at most CD_W+1 cycles, then -> SEND with byte index 0.
REQ-023 SEND: when is_transmitting=0, transmit=1 for exactly one cycle with tx_byte = byte[index], -> WAIT_BUSY; otherwise wait in SEND.
REQ-024 WAIT_BUSY -> WAIT_DONE on is_transmitting=1, or after 4 cycles without it (byte treated as sent).
REQ-025 WAIT_DONE: on is_transmitting=0, increment index -> SEND, or -> IDLE after the last byte.
REQ-026 tx_byte shall hold its last value between strobes; transmit shall never be high on two consecutive cycles.
REQ-027 First transmit strobe shall occur no later than CD_W+3 cycles after pending is set with FSM idle and UART idle.

Reset
REQ-028 On reset_n=0 at a clk edge: transmit=0, tx_byte=0x00, FSM=IDLE, index=0, heartbeat counter=0, previous-value registers=0.
REQ-029 pending shall be 1 after reset, so a boot frame is sent.
REQ-030 Reset mid-frame shall abort the frame at once; the next frame restarts from byte 0.

Configuration
REQ-031 Macro STATUS_TX_ANSI_EN defined: each frame is prefixed with ESC (0x1B), '[', '2', 'K', CR, making 19 bytes, so a terminal redraws one status line.
REQ-032 Macro STATUS_TX_ANSI_EN undefined: no prefix, 14-byte frame per REQ-012; no ANSI logic present.

Verification
REQ-033 Release reset with score=0x0000, count_down=60, start=0, over=0, UART model busy 10 cycles per byte -> boot frame "S0000 T060 I\r\n", 14 strobes, each 1 cycle wide, each only while is_transmitting=0.
REQ-034 Change score 0x0000->0x0123 during byte 5 of a frame -> current frame completes with old score; exactly one further frame "S0123 T060 I\r\n" follows.
REQ-035 Set start=1, over=1, score=0x00A9, count_down=0 -> frame "S00?9 T000 O\r\n".
REQ-036 Hold is_transmitting=0 permanently -> each strobe followed by a 4-cycle WAIT_BUSY timeout; frame completes with 14 strobes.
REQ-037 Assert reset_n=0 for 1 cycle at byte 7 -> transmit=0 next cycle; boot frame restarts at 'S' (or ESC with STATUS_TX_ANSI_EN).
REQ-038 HEARTBEAT_TICKS=1000, stable inputs -> one frame start every 1000 cycles after the previous frame start, with identical content.
